// File: rtl/poly1305_fmt_pkg.sv
// rtl/poly1305_fmt_pkg.sv - shared types, constants and byte-mask helper for the Poly1305 block formatter
package poly1305_fmt_pkg;

    localparam int BLK_BYTES = 16;
    localparam int BLK_W     = BLK_BYTES * 8;
    localparam int LEN_W_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_AAD  = 2'd1,
        ST_CT   = 2'd2,
        ST_LEN  = 2'd3
    } fmt_state_e;

    // Ones in every byte lane below nbytes, zeros above; byte 0 sits at [7:0].
    function automatic logic [BLK_W-1:0] byte_mask(input logic [4:0] nbytes);
        logic [BLK_W-1:0] m;
        m = '0;
        for (int i = 0; i < BLK_BYTES; i++) begin
            if (5'(i) < nbytes) begin
                m[i*8 +: 8] = 8'hFF;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/poly1305_block_formatter.sv
// rtl/poly1305_block_formatter.sv - pads AAD/CT segments to 16-byte blocks and appends the length block
module poly1305_block_formatter
    import poly1305_fmt_pkg::*;
#(
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic         skip_aad,
    input  logic         skip_ct,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [4:0]   in_bytes,
    input  logic         in_last,
    input  logic         in_seg,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic [127:0] blk_data,
    output logic         blk_final,
    output logic         busy,
    output logic         done,
    output logic         err
);

    fmt_state_e         state_q, state_d;
    logic               skip_ct_q, skip_ct_d;
    logic [LEN_W-1:0]   aad_len_q, aad_len_d;
    logic [LEN_W-1:0]   ct_len_q, ct_len_d;
    logic [127:0]       blk_data_q, blk_data_d;
    logic               blk_valid_q, blk_valid_d;
    logic               blk_final_q, blk_final_d;
    logic               err_q, err_d;
    logic               done_q, done_d;

    logic               in_seg_state;
    logic               out_free;
    logic               accept;
    logic               malformed;
    logic               good;
    logic               final_hs;
    logic               len_load;

    // Handshake qualifiers shared by the next-state and output logic.
    always_comb begin
        in_seg_state = (state_q == ST_CT);
        out_free     = !blk_valid_q || blk_ready;
        accept       = in_valid && in_ready;
        malformed    = (in_bytes == 5'd0) || (in_bytes > 5'd16) ||
                       ((in_bytes < 5'd16) && !in_last) || (in_seg != in_seg_state);
        good         = accept && !malformed;
        final_hs     = blk_valid_q && blk_final_q && blk_ready;
        // Length block goes out once per message: blk_final_q marks it already loaded.
        len_load     = (state_q == ST_LEN) && out_free && !blk_final_q;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: segments advance on any accepted in_last, malformed or not.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (!skip_aad)     state_d = ST_AAD;
                    else if (!skip_ct) state_d = ST_CT;
                    else               state_d = ST_LEN;
                end
            end
            ST_AAD: begin
                if (accept && in_last) state_d = skip_ct_q ? ST_LEN : ST_CT;
            end
            ST_CT: begin
                if (accept && in_last) state_d = ST_LEN;
            end
            ST_LEN: begin
                if (final_hs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs and datapath next values: output register, counters, error and done.
    always_comb begin
        in_ready    = ((state_q == ST_AAD) || (state_q == ST_CT)) && out_free;
        busy        = (state_q != ST_IDLE);
        skip_ct_d   = skip_ct_q;
        aad_len_d   = aad_len_q;
        ct_len_d    = ct_len_q;
        blk_data_d  = blk_data_q;
        blk_valid_d = blk_valid_q;
        blk_final_d = blk_final_q;
        err_d       = err_q;
        done_d      = 1'b0;

        if ((state_q == ST_IDLE) && start) begin
            aad_len_d = '0;
            ct_len_d  = '0;
            err_d     = 1'b0;
            skip_ct_d = skip_ct;
        end

        // Drain first; a load on the same edge overrides it.
        if (blk_valid_q && blk_ready) begin
            blk_valid_d = 1'b0;
            blk_final_d = 1'b0;
        end

        if (good) begin
            blk_data_d  = in_data & byte_mask(in_bytes);
            blk_valid_d = 1'b1;
            blk_final_d = 1'b0;
            if (state_q == ST_CT) ct_len_d  = ct_len_q + LEN_W'(in_bytes);
            else                  aad_len_d = aad_len_q + LEN_W'(in_bytes);
        end

        if (accept && malformed) begin
            err_d = 1'b1;
        end

        if (len_load) begin
            blk_data_d  = {64'(ct_len_q), 64'(aad_len_q)};
            blk_valid_d = 1'b1;
            blk_final_d = 1'b1;
        end

        if (final_hs) begin
            done_d = 1'b1;
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skip_ct_q   <= 1'b0;
            aad_len_q   <= '0;
            ct_len_q    <= '0;
            blk_data_q  <= '0;
            blk_valid_q <= 1'b0;
            blk_final_q <= 1'b0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            skip_ct_q   <= skip_ct_d;
            aad_len_q   <= aad_len_d;
            ct_len_q    <= ct_len_d;
            blk_data_q  <= blk_data_d;
            blk_valid_q <= blk_valid_d;
            blk_final_q <= blk_final_d;
            err_q       <= err_d;
            done_q      <= done_d;
        end
    end

    assign blk_data  = blk_data_q;
    assign blk_valid = blk_valid_q;
    assign blk_final = blk_final_q;
    assign err       = err_q;
    assign done      = done_q;

endmodule

// File: tb/tb_poly1305_block_formatter.sv
// tb/tb_poly1305_block_formatter.sv - directed self-checking bench for poly1305_block_formatter
module tb_poly1305_block_formatter;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start, skip_aad, skip_ct;
    logic         in_valid, in_ready;
    logic [127:0] in_data;
    logic [4:0]   in_bytes;
    logic         in_last, in_seg;
    logic         blk_valid, blk_ready;
    logic [127:0] blk_data;
    logic         blk_final;
    logic         busy, done, err;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    logic [128:0] blk_q[$];

    localparam logic [127:0] DA = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
    localparam logic [127:0] DB = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
    localparam logic [127:0] DC = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;
    localparam logic [127:0] DE = 128'hE0E1E2E3_E4E5E6E7_E8E9EAEB_ECEDEEEF;
    localparam logic [127:0] DF = 128'hF0F1F2F3_F4F5F6F7_F8F9FAFB_FCFDFEFF;

    poly1305_block_formatter dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .skip_aad  (skip_aad),
        .skip_ct   (skip_ct),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .in_last   (in_last),
        .in_seg    (in_seg),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_final (blk_final),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Record every block handshake and done pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if (reset_n && blk_valid && blk_ready) blk_q.push_back({blk_final, blk_data});
        if (reset_n && done) done_cnt++;
    end

    task automatic chk(input string tag, input logic [128:0] obs, input logic [128:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [128:0] blk_at(input int i);
        if (i < blk_q.size()) return blk_q[i];
        return {129{1'bx}};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic sa, input logic sc);
        start = 1'b1; skip_aad = sa; skip_ct = sc;
        tick();
        start = 1'b0; skip_aad = 1'b0; skip_ct = 1'b0;
    endtask

    task automatic send_chunk(input logic [127:0] d, input logic [4:0] nb, input logic last, input logic seg);
        int n;
        logic rdy;
        in_valid = 1'b1; in_data = d; in_bytes = nb; in_last = last; in_seg = seg;
        n = 0;
        do begin
            @(negedge clk);
            rdy = in_ready;
            tick();
            n++;
        end while (!rdy && n < 64);
        in_valid = 1'b0;
        if (!rdy) chk("send_timeout", 129'd0, 129'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 64) begin
            tick();
            n++;
        end
        chk(tag, {128'd0, busy}, 129'd0);
        tick();
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_in_ready"},  {128'd0, in_ready},  129'd0);
        chk({tag, "_blk_valid"}, {128'd0, blk_valid}, 129'd0);
        chk({tag, "_blk_data"},  {1'b0, blk_data},    129'd0);
        chk({tag, "_blk_final"}, {128'd0, blk_final}, 129'd0);
        chk({tag, "_busy"},      {128'd0, busy},      129'd0);
        chk({tag, "_done"},      {128'd0, done},      129'd0);
        chk({tag, "_err"},       {128'd0, err},       129'd0);
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; skip_aad = 1'b0; skip_ct = 1'b0;
        in_valid = 1'b0; in_data = '0; in_bytes = '0; in_last = 1'b0; in_seg = 1'b0;
        blk_ready = 1'b1;
        tick(); tick();
        check_outputs_zero("rst");
        reset_n = 1'b1;
        tick();

        // AAD 12 bytes, CT 16 bytes, sink always ready
        blk_q.delete(); done_cnt = 0;
        do_start(1'b0, 1'b0);
        send_chunk(128'h00112233_44556677_8899AABB_CCDDEEFF, 5'd12, 1'b1, 1'b0);
        chk("t1_lat_valid", {128'd0, blk_valid}, 129'd1);
        chk("t1_lat_data", {1'b0, blk_data}, {1'b0, 128'h00000000_44556677_8899AABB_CCDDEEFF});
        send_chunk(DB, 5'd16, 1'b1, 1'b1);
        wait_idle("t1_idle");
        chk("t1_nblk", 129'(blk_q.size()), 129'd3);
        chk("t1_b0", blk_at(0), {1'b0, 128'h00000000_44556677_8899AABB_CCDDEEFF});
        chk("t1_b1", blk_at(1), {1'b0, DB});
        chk("t1_b2", blk_at(2), {1'b1, 128'h0000000000000010_000000000000000C});
        chk("t1_done", 129'(done_cnt), 129'd1);

        // Both segments skipped: zero length block two cycles after start
        blk_q.delete(); done_cnt = 0;
        blk_ready = 1'b0;
        do_start(1'b1, 1'b1);
        chk("t2_early_valid", {128'd0, blk_valid}, 129'd0);
        tick();
        chk("t2_valid", {128'd0, blk_valid}, 129'd1);
        chk("t2_final", {128'd0, blk_final}, 129'd1);
        chk("t2_data", {1'b0, blk_data}, 129'd0);
        chk("t2_busy", {128'd0, busy}, 129'd1);
        blk_ready = 1'b1;
        tick();
        chk("t2_done_hi", {128'd0, done}, 129'd1);
        chk("t2_busy_lo", {128'd0, busy}, 129'd0);
        tick();
        chk("t2_done_lo", {128'd0, done}, 129'd0);
        chk("t2_nblk", 129'(blk_q.size()), 129'd1);
        chk("t2_done_cnt", 129'(done_cnt), 129'd1);

        // Back-pressure: sink stalls 5 cycles with the next chunk waiting
        blk_q.delete(); done_cnt = 0;
        blk_ready = 1'b0;
        do_start(1'b0, 1'b0);
        send_chunk(DA, 5'd16, 1'b0, 1'b0);
        in_valid = 1'b1; in_data = DB; in_bytes = 5'd16; in_last = 1'b1; in_seg = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t3_in_ready", {128'd0, in_ready}, 129'd0);
            chk("t3_hold", {1'b0, blk_data}, {1'b0, DA});
            tick();
        end
        blk_ready = 1'b1;
        send_chunk(DB, 5'd16, 1'b1, 1'b0);
        send_chunk(DC, 5'd3, 1'b1, 1'b1);
        wait_idle("t3_idle");
        chk("t3_nblk", 129'(blk_q.size()), 129'd4);
        chk("t3_b0", blk_at(0), {1'b0, DA});
        chk("t3_b1", blk_at(1), {1'b0, DB});
        chk("t3_b2", blk_at(2), {1'b0, 128'h00000000_00000000_00000000_00CDCECF});
        chk("t3_b3", blk_at(3), {1'b1, 128'h0000000000000003_0000000000000020});

        // Short chunk without in_last is rejected and does not count
        blk_q.delete(); done_cnt = 0;
        do_start(1'b0, 1'b0);
        send_chunk(DF, 5'd7, 1'b0, 1'b0);
        chk("t4_err", {128'd0, err}, 129'd1);
        chk("t4_no_blk", {128'd0, blk_valid}, 129'd0);
        send_chunk(DE, 5'd4, 1'b1, 1'b0);
        send_chunk(DF, 5'd2, 1'b1, 1'b1);
        wait_idle("t4_idle");
        chk("t4_nblk", 129'(blk_q.size()), 129'd3);
        chk("t4_b0", blk_at(0), {1'b0, 128'h00000000_00000000_00000000_ECEDEEEF});
        chk("t4_b1", blk_at(1), {1'b0, 128'h00000000_00000000_00000000_0000FEFF});
        chk("t4_b2", blk_at(2), {1'b1, 128'h0000000000000002_0000000000000004});
        chk("t4_err_sticky", {128'd0, err}, 129'd1);
        blk_q.delete();
        do_start(1'b0, 1'b1);
        chk("t4_err_clr", {128'd0, err}, 129'd0);
        send_chunk(DC, 5'd1, 1'b1, 1'b0);
        wait_idle("t4b_idle");
        chk("t4b_b1", blk_at(1), {1'b1, 128'h0000000000000000_0000000000000001});

        // Wrong segment tag dropped, then AAD 32 bytes and CT 1 byte
        blk_q.delete(); done_cnt = 0;
        do_start(1'b0, 1'b0);
        send_chunk(DE, 5'd16, 1'b0, 1'b1);
        chk("t5_err", {128'd0, err}, 129'd1);
        chk("t5_no_blk", {128'd0, blk_valid}, 129'd0);
        send_chunk(DA, 5'd16, 1'b0, 1'b0);
        send_chunk(DB, 5'd16, 1'b1, 1'b0);
        send_chunk(DC, 5'd1, 1'b1, 1'b1);
        wait_idle("t5_idle");
        chk("t5_nblk", 129'(blk_q.size()), 129'd4);
        chk("t5_b0", blk_at(0), {1'b0, DA});
        chk("t5_b2", blk_at(2), {1'b0, 128'h00000000_00000000_00000000_000000CF});
        chk("t5_b3", blk_at(3), {1'b1, 128'h0000000000000001_0000000000000020});

        // Reset while a CT block is pending, then a clean message
        blk_ready = 1'b0;
        do_start(1'b1, 1'b0);
        send_chunk(DA, 5'd16, 1'b0, 1'b1);
        chk("t6_pending", {128'd0, blk_valid}, 129'd1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("t6_rst");
        tick();
        reset_n = 1'b1;
        blk_ready = 1'b1;
        tick();
        blk_q.delete(); done_cnt = 0;
        do_start(1'b0, 1'b1);
        send_chunk(DC, 5'd5, 1'b1, 1'b0);
        wait_idle("t6_idle");
        chk("t6_nblk", 129'(blk_q.size()), 129'd2);
        chk("t6_b0", blk_at(0), {1'b0, 128'h00000000_00000000_000000CB_CCCDCECF});
        chk("t6_b1", blk_at(1), {1'b1, 128'h0000000000000000_0000000000000005});
        chk("t6_done", 129'(done_cnt), 129'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/poly1305_block_formatter.md
# poly1305_block_formatter

Upstream feeder for the ChaCha20-Poly1305 tag path. Accepts AAD and ciphertext as 128-bit little-endian chunks and zero-pads each segment to a 16-byte boundary. It then appends the RFC 8439 length block and presents the result as a stream of 128-bit Poly1305 message blocks over a valid/ready handshake. It tracks segment byte counts, rejects malformed chunks, and signals end-of-message so the downstream accumulator can request the tag.

## Interface
- LEN_W, 64, width of each segment byte counter (RFC 8439 fixes 64).
- clk  in  1  clock; all logic on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a message; honoured only in IDLE.
- skip_aad  in  1  sampled with start; AAD segment is empty.
- skip_ct  in  1  sampled with start; CT segment is empty.
- in_valid  in  1  chunk present.
- in_ready  out  1  chunk accepted when in_valid & in_ready.
- in_data  in  128  chunk; byte 0 at [7:0].
- in_bytes  in  5  valid bytes in the chunk, 1..16.
- in_last  in  1  final chunk of the current segment.
- in_seg  in  1  0 = AAD, 1 = CT; must match the current state.
- blk_valid  out  1  block present.
- blk_ready  in  1  downstream accepts the block.
- blk_data  out  128  padded block or length block.
- blk_final  out  1  qualifies blk_data as the length block.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse after the length block handshake.
- err  out  1  sticky malformed-input flag; cleared by start.

## Operation
- States: IDLE, AAD, CT, LEN.
- IDLE + start: clear both counters and err, then go to AAD. If skip_aad, go to CT instead; if skip_aad and skip_ct, go to LEN.
- AAD/CT accept: the chunk is masked so bytes at index ≥ in_bytes are zero, loaded into the output register, and the segment counter is incremented by in_bytes.
- in_last accepted in AAD: go to CT, or to LEN if skip_ct. in_last accepted in CT: go to LEN.
- Malformed chunk, in any of these cases:
  - in_bytes == 0 or in_bytes > 16;
  - in_bytes < 16 without in_last;
  - in_seg mismatching the state.
- On a malformed chunk: it is consumed (in_ready high), not forwarded, counters are unchanged, and err is set. The state advances only if in_last is set.
- LEN: once the output register is free, load {ct_len[63:0], aad_len[63:0]} (aad_len at [63:0]) with blk_final = 1.
- On handshake of the length block: pulse done and return to IDLE.
- Counters wrap modulo 2^LEN_W; there is no overflow detection.
- start outside IDLE is ignored. in_valid in IDLE or LEN is not accepted (in_ready = 0).

## Timing
- Reset values: in_ready 0, blk_valid 0, blk_data 0, blk_final 0, busy 0, done 0, err 0; state IDLE; counters 0.
- Output register is single-entry. in_ready = (state is AAD or CT) & (!blk_valid | blk_ready), so back-to-back acceptance runs at 1 chunk/cycle.
- Latency: an accepted chunk appears on blk_data the next cycle.
- The length block is loaded in the first LEN cycle with a free output register: at the earliest, the cycle after the last CT chunk is accepted, if that chunk drains on the same edge.
- blk_data and blk_final hold stable while blk_valid & !blk_ready.
- done is asserted in the cycle after the final handshake; busy deasserts on that same cycle.
- start together with skip_aad and skip_ct: blk_valid rises 2 cycles later, carrying an all-zero length block.
- Reset mid-message: everything returns to reset values immediately, and any pending block is discarded.

## Structure
- Shared package poly1305_fmt_pkg: state enum, BLK_BYTES = 16, LEN_W default, and the byte-mask function (in_bytes → 128-bit mask).
- No sub-module. The single-entry output register, the two counters and the FSM live in one module.

## Test plan
- Message of AAD 12 bytes then CT 16 bytes, blk_ready held high:
  - block 1 = AAD with bytes 12..15 zero;
  - block 2 = CT unchanged;
  - block 3 = 0x0000000000000010_000000000000000C with blk_final = 1;
  - done pulses once.
- skip_aad = skip_ct = 1 → a single block of 0 with blk_final = 1; done fires 1 cycle after the handshake.
- Back-pressure: blk_ready low for 5 cycles while in_valid is high → in_ready is low, blk_data holds stable, and no chunk is lost or duplicated; counts are correct at the end.
- Malformed input: in_bytes = 7 without in_last in AAD → err = 1, no block emitted, aad_len unchanged. A subsequent start clears err.
- in_seg = 1 during AAD → err = 1 and the chunk is dropped. An AAD of 32 bytes (2 full chunks) followed by CT of 1 byte gives length block {1, 32}.
- reset_n asserted low while blk_valid = 1 in CT → all outputs 0 immediately; a fresh start then produces correct results.
